// File: rtl/rast_pipe_pkg.sv
// Shared pipeline definitions for the raster pipe blocks.
// Holds the skid-buffer occupancy state encoding used by array_skid_buffer.
package rast_pipe_pkg;

  // Occupancy of the two-register skid buffer
  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // no word held
    BUSY  = 2'd1,  // main register holds a word
    FULL  = 2'd2   // main and skid registers both hold words
  } skid_state_e;

endpackage

// File: rtl/array_slot_reg.sv
// One ARRAY_SIZE x WIDTH word register with a single load enable.
// All elements are written together; synchronous active-high reset clears
// every element to zero.
module array_slot_reg
  import rast_pipe_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int ARRAY_SIZE = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data [ARRAY_SIZE],
  output logic [WIDTH-1:0] o_data [ARRAY_SIZE]
);

  logic [WIDTH-1:0] r_data [ARRAY_SIZE];

  // Whole-word capture on load; reset wins over load
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        r_data[i] <= '0;
      end
    end else if (i_load) begin
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        r_data[i] <= i_data[i];
      end
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/array_skid_buffer.sv
// Two-entry skid buffer for array-valued words (valid/ready handshake).
// The main register drives out_data; the skid register catches the word
// accepted while the downstream stalls. in_ready and out_valid are decoded
// from registered state, so out_ready never reaches in_ready combinationally.
// Optional feature: define ARRAY_SKID_FLUSH_EN to add the flush input, which
// drops all held words (a concurrent out-fire still completes).
module array_skid_buffer
  import rast_pipe_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int ARRAY_SIZE = 64
) (
  input  logic             clk,
  input  logic             reset,
`ifdef ARRAY_SKID_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data  [ARRAY_SIZE],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data [ARRAY_SIZE]
);

  skid_state_e      r_state;
  logic             r_out_valid;
  logic             r_in_ready;

  logic             w_flush;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_ld;
  logic             w_skid_ld;
  logic             w_main_from_skid;
  logic [WIDTH-1:0] w_main_d [ARRAY_SIZE];
  logic [WIDTH-1:0] w_skid_q [ARRAY_SIZE];

`ifdef ARRAY_SKID_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // flush blocks new words in the same cycle it is raised
  assign in_ready   = r_in_ready & ~w_flush;
  assign out_valid  = r_out_valid;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // Register load enables and main-source select from state and handshakes
  always_comb begin
    w_main_ld        = 1'b0;
    w_skid_ld        = 1'b0;
    w_main_from_skid = 1'b0;
    if (!w_flush) begin
      case (r_state)
        EMPTY: w_main_ld = w_in_fire;
        BUSY: begin
          w_main_ld = w_in_fire & w_out_fire;
          w_skid_ld = w_in_fire & ~w_out_fire;
        end
        FULL: begin
          w_main_ld        = w_out_fire;
          w_main_from_skid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Main register refills from the skid word when draining FULL
  always_comb begin
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      w_main_d[i] = w_main_from_skid ? w_skid_q[i] : in_data[i];
    end
  end

  // Occupancy FSM with registered out_valid / in_ready
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (w_flush) begin
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            r_state     <= BUSY;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b1;
          end
        end
        BUSY: begin
          if (w_in_fire && !w_out_fire) begin
            r_state     <= FULL;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b0;
          end else if (!w_in_fire && w_out_fire) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        FULL: begin
          if (w_out_fire) begin
            r_state     <= BUSY;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  array_slot_reg #(
    .WIDTH      (WIDTH),
    .ARRAY_SIZE (ARRAY_SIZE)
  ) u_main (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_main_ld),
    .i_data (w_main_d),
    .o_data (out_data)
  );

  array_slot_reg #(
    .WIDTH      (WIDTH),
    .ARRAY_SIZE (ARRAY_SIZE)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_skid_ld),
    .i_data (in_data),
    .o_data (w_skid_q)
  );

endmodule

// File: tb/tb_array_skid_buffer.sv
// Testbench for array_skid_buffer: a 64x64 instance and a 1x1 instance share
// the same handshake stimulus; the 1x1 instance sees bit 0 of element 0.
// An occupancy/order model predicts in_ready, out_valid and out_data.
module tb_array_skid_buffer;

  localparam int W = 64;
  localparam int N = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         in_valid;
  logic         out_ready;
  logic         in_ready, out_valid;
  logic         in_ready_s, out_valid_s;
  logic [W-1:0] in_data  [N];
  logic [W-1:0] out_data [N];
  logic [0:0]   in_data_s  [1];
  logic [0:0]   out_data_s [1];
`ifdef ARRAY_SKID_FLUSH_EN
  logic         flush;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int q[$];
  int next_seq = 0;
  int n_out = 0;
  string phase;

  always_comb in_data_s[0] = in_data[0][0:0];

  array_skid_buffer #(.WIDTH(W), .ARRAY_SIZE(N)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef ARRAY_SKID_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  array_skid_buffer #(.WIDTH(1), .ARRAY_SIZE(1)) dut_s (
    .clk       (clk),
    .reset     (reset),
`ifdef ARRAY_SKID_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready_s),
    .in_data   (in_data_s),
    .out_valid (out_valid_s),
    .out_ready (out_ready),
    .out_data  (out_data_s)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Element i of word number s
  function automatic logic [63:0] elem(input int s, input int i);
    logic [31:0] hi;
    logic [31:0] lo;
    hi = i ^ 32'h5A00_0000;
    lo = s;
    return {hi, lo};
  endfunction

  function automatic logic [63:0] sig_of(input logic [W-1:0] a [N]);
    logic [63:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++) acc += a[i] ^ (64'(i) * 64'h9E37_79B9_7F4A_7C15);
    return acc;
  endfunction

  function automatic logic [63:0] sig_exp(input int s);
    logic [63:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++) acc += elem(s, i) ^ (64'(i) * 64'h9E37_79B9_7F4A_7C15);
    return acc;
  endfunction

  function automatic logic [63:0] or_all(input logic [W-1:0] a [N]);
    logic [63:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++) acc |= a[i];
    return acc;
  endfunction

  // One clock cycle: drive, check against the model mid-cycle, update model at the edge
  task automatic run_cycle(input bit iv, input bit ordy, input bit rs, input bit fl);
    bit exp_rdy, exp_vld, ifire, ofire;
    logic [63:0] e0;
    int s;
    in_valid  = iv;
    out_ready = ordy;
    reset     = rs;
`ifdef ARRAY_SKID_FLUSH_EN
    flush     = fl;
`endif
    for (int i = 0; i < N; i++) in_data[i] = elem(next_seq, i);
    ifire = 1'b0;
    ofire = 1'b0;
    @(negedge clk);
    if (!rs) begin
      exp_rdy = (q.size() < 2) && !fl;
      exp_vld = (q.size() != 0);
      chk({phase, "_in_ready"},    64'(in_ready),    64'(exp_rdy));
      chk({phase, "_out_valid"},   64'(out_valid),   64'(exp_vld));
      chk({phase, "_in_ready_s"},  64'(in_ready_s),  64'(exp_rdy));
      chk({phase, "_out_valid_s"}, 64'(out_valid_s), 64'(exp_vld));
      if (exp_vld) begin
        s  = q[0];
        e0 = elem(s, 0);
        chk({phase, "_data0"},  out_data[0],       e0);
        chk({phase, "_datasig"}, sig_of(out_data), sig_exp(s));
        chk({phase, "_data_s"}, 64'(out_data_s[0]), 64'(e0[0]));
      end
      ifire = iv && exp_rdy;
      ofire = exp_vld && ordy;
    end
    @(posedge clk);
    if (rs) begin
      q.delete();
    end else begin
      if (ofire) begin
        void'(q.pop_front());
        n_out++;
      end
      if (ifire) begin
        q.push_back(next_seq);
        next_seq++;
      end
      if (fl) q.delete();
    end
    #1;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_out_valid"},   64'(out_valid),   64'd0);
    chk({tag, "_in_ready"},    64'(in_ready),    64'd1);
    chk({tag, "_zero"},        or_all(out_data), 64'd0);
    chk({tag, "_out_valid_s"}, 64'(out_valid_s), 64'd0);
    chk({tag, "_in_ready_s"},  64'(in_ready_s),  64'd1);
    chk({tag, "_zero_s"},      64'(out_data_s[0]), 64'd0);
  endtask

  initial begin
    int cyc;
    int a_seq;
    logic [63:0] ea;

    // Reset state
    phase = "reset";
    repeat (3) run_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk_cleared("reset");

    // Streaming: one word per cycle, one-cycle latency
    phase = "stream";
    repeat (8) run_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) run_cycle(1'b0, 1'b1, 1'b0, 1'b0);

    // Stall: A, B fill the buffer, then drain in order
    phase = "full";
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("full_in_ready_after_B", 64'(in_ready), 64'd0);
    repeat (3) run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("full_in_ready_after_A_out", 64'(in_ready), 64'd1);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset while FULL, with both handshakes active
    phase = "rstfull";
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rstfull_in_ready_full", 64'(in_ready), 64'd0);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    chk_cleared("rstfull");
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef ARRAY_SKID_FLUSH_EN
    // Flush while FULL: A leaves this cycle, B is dropped
    phase = "flush";
    a_seq = next_seq;
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b1);
    ea = elem(a_seq, 0);
    chk("flush_out_valid_next", 64'(out_valid), 64'd0);
    chk("flush_in_ready_next",  64'(in_ready),  64'd1);
    chk("flush_main_kept",      out_data[0],    ea);
    repeat (2) run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
`else
    a_seq = 0;
    ea    = '0;
`endif

    // Random handshakes, scoreboard checks order and occupancy
    phase = "rand";
    n_out = 0;
    cyc   = 0;
    while (n_out < 10000 && cyc < 60000) begin
      run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      cyc++;
    end
    chk("rand_delivered", 64'(n_out), 64'd10000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/array_skid_buffer.md
ARRAY_SKID_BUFFER -- requirements
Module: array_skid_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 64, bit width of each array element.
REQ-002 SHALL have parameter ARRAY_SIZE, default 64, number of elements per transfer.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  upstream word offered.
REQ-006 SHALL have port in_ready  output  1  block accepts upstream word this cycle.
REQ-007 SHALL have port in_data  input  WIDTH x [ARRAY_SIZE] unpacked array  upstream word.
REQ-008 SHALL have port out_valid  output  1  downstream word presented.
REQ-009 SHALL have port out_ready  input  1  downstream accepts word this cycle.
REQ-010 SHALL have port out_data  output  WIDTH x [ARRAY_SIZE] unpacked array  downstream word.
REQ-011 SHALL have port flush  input  1  discard all held words; present only when ARRAY_SKID_FLUSH_EN is defined.

Function
REQ-012 SHALL define in-fire = in_valid & in_ready and out-fire = out_valid & out_ready, both sampled at the rising clk edge.
REQ-013 SHALL hold two word registers: main (drives out_data) and skid.
REQ-014 SHALL implement a 3-state FSM: EMPTY (no word), BUSY (main valid), FULL (main and skid valid).
REQ-015 SHALL drive out_valid = (state != EMPTY) and in_ready = (state != FULL), both decoded from registered state only (no out_ready-to-in_ready combinational path).
REQ-016 SHALL, in EMPTY on in-fire, load main <= in_data and go to BUSY.
REQ-017 SHALL, in BUSY, on in-fire with out-fire load main <= in_data and stay BUSY.
REQ-018 SHALL, in BUSY, on in-fire without out-fire load skid <= in_data and go to FULL.
REQ-019 SHALL, in BUSY, on out-fire without in-fire go to EMPTY; with neither, hold state and data.
REQ-020 SHALL, in FULL, on out-fire load main <= skid and go to BUSY; otherwise hold.
REQ-021 SHALL give 1-cycle latency: a word accepted in EMPTY appears on out_data/out_valid the next cycle.
REQ-022 SHALL preserve word order and never drop or duplicate a word; throughput one word per cycle when out_ready is held high.
REQ-023 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-024 SHALL copy all ARRAY_SIZE elements atomically; no per-element enable.

Reset
REQ-025 SHALL, when reset=1 at a clk edge, set state to EMPTY and main and skid to all zeros, overriding any concurrent handshake.
REQ-026 SHALL therefore present out_valid=0, out_data=0, in_ready=1 in the cycle after reset; words held when reset asserts mid-operation are lost.

Configuration
REQ-027 SHALL, with ARRAY_SKID_FLUSH_EN defined, add port flush: flush=1 (reset=0) forces in_ready=0 that cycle, completes any out-fire normally, and sets state EMPTY next cycle with registers unchanged.
REQ-028 SHALL, without ARRAY_SKID_FLUSH_EN, omit port flush and all flush logic; behaviour equals flush tied 0.

Structure
REQ-029 SHALL place the FSM state enum typedef (EMPTY, BUSY, FULL; 2 bits) in shared package rast_pipe_pkg.
REQ-030 SHALL instantiate sub-module array_slot_reg (one ARRAY_SIZE x WIDTH register with load enable and sync reset) twice, for main and skid.

Verification
REQ-031 SHALL cover: after reset, in_valid=1 with in_data[i]=i every cycle, out_ready=1 -> out_data[i] equals word sent one cycle earlier, one word/cycle, in_ready=1 throughout.
REQ-032 SHALL cover: send words A,B with out_ready=0 -> state FULL, in_ready=0 after B, out_data=A stable; raise out_ready -> A then B delivered, in_ready=1 after A's out-fire.
REQ-033 SHALL cover: random in_valid/out_ready (50% each) over 10000 words -> scoreboard shows in-order, loss-free delivery, no in-fire while state FULL.
REQ-034 SHALL cover: reset asserted in FULL -> next cycle out_valid=0, out_data all zeros, in_ready=1.
REQ-035 SHALL cover (ARRAY_SKID_FLUSH_EN): flush=1 in FULL with out_ready=1 -> A consumed that cycle, B discarded, next cycle out_valid=0.
REQ-036 SHALL cover: parameters WIDTH=1, ARRAY_SIZE=1 and WIDTH=64, ARRAY_SIZE=64 -> REQ-031 and REQ-032 pass unchanged.
